regfile_mp: RTL and testbench

//  Parametrised multi-port integer register file for the RV32I core family; supersedes the single-write design.
//  NRD combinational read ports, two synchronous write ports (P0: ALU/jump/AUIPC result, P1: load writeback),

---
 rtl/regfile_mp.sv | 156 +++++++++++++++
 tb/tb_regfile_mp.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
`default_nettype none
// ----------------------------------------------------------------------------
// regfile_mp : multi-port RV32I register file with bypass, load scoreboard,
//              and multi-cycle soft-clear sweep.          Revision 1.0
// ----------------------------------------------------------------------------
module regfile_mp #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int NRD    = 2,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NRD*AW-1:0]    rd_addr,
  output logic [NRD*XLEN-1:0]  rd_data,
  output logic [NRD-1:0]       rd_busy,
  input  logic                 wr0_en,
  input  logic [AW-1:0]        wr0_addr,
  input  logic [1:0]           wr0_src,
  input  logic [XLEN-1:0]      wr0_data,
  input  logic [XLEN-1:0]      wr0_pc4,
  input  logic [XLEN-1:0]      wr0_npc,
  input  logic                 wr1_en,
  input  logic [AW-1:0]        wr1_addr,
  input  logic [XLEN-1:0]      wr1_data,
  input  logic                 sb_set,
  input  logic [AW-1:0]        sb_addr,
  input  logic                 clear_req,
  output logic                 clear_busy,
  output logic                 wr_err
);

  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);
  localparam logic [1:0]    SRC_ILL  = 2'b11;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_SWEEP = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic            clear_busy_q, clear_busy_d;
  logic            wr_err_q, wr_err_d;
  logic [XLEN-1:0] rf_q [NREGS];
  logic [XLEN-1:0] rf_d [NREGS];
  logic [NREGS-1:0] busy_q, busy_d;

  logic            sweeping;
  logic [XLEN-1:0] wr0_val;
  logic            wr0_ok, wr1_ok, sb_ok, collide;

  always_comb begin
    sweeping = (state_q == S_SWEEP);
    case (wr0_src)
      2'b01:   wr0_val = wr0_pc4;
      2'b10:   wr0_val = wr0_npc;
      default: wr0_val = wr0_data;
    endcase
    collide = wr0_en && wr1_en && (wr0_addr == wr1_addr) && (wr0_addr != '0);
    // P1 wins a same-address collision, so P0 is dropped outright
    wr0_ok  = !sweeping && wr0_en && (wr0_addr != '0) && (wr0_src != SRC_ILL) && !collide;
    wr1_ok  = !sweeping && wr1_en && (wr1_addr != '0);
    sb_ok   = !sweeping && sb_set && (sb_addr != '0);
    wr_err_d = !sweeping && ((wr0_en && (wr0_src == SRC_ILL)) || collide);
  end

  always_comb begin
    rf_d   = rf_q;
    busy_d = busy_q;
    if (wr0_ok) rf_d[wr0_addr] = wr0_val;
    if (wr1_ok) begin
      rf_d[wr1_addr]   = wr1_data;
      busy_d[wr1_addr] = 1'b0;
    end
    if (sb_ok) busy_d[sb_addr] = 1'b1;
    if (sweeping) begin
      rf_d[idx_q]   = '0;
      busy_d[idx_q] = 1'b0;
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    clear_busy_d = clear_busy_q;
    case (state_q)
      S_IDLE: begin
        if (clear_req) begin
          state_d      = S_SWEEP;
          idx_d        = AW'(1);
          clear_busy_d = 1'b1;
        end
      end
      S_SWEEP: begin
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d      = S_IDLE;
          clear_busy_d = 1'b0;
        end
      end
      default: begin
        state_d      = S_IDLE;
        clear_busy_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      clear_busy_q <= 1'b0;
      wr_err_q     <= 1'b0;
      busy_q       <= '0;
      rf_q         <= '{default: '0};
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      clear_busy_q <= clear_busy_d;
      wr_err_q     <= wr_err_d;
      busy_q       <= busy_d;
      rf_q         <= rf_d;
    end
  end

  assign clear_busy = clear_busy_q;
  assign wr_err     = wr_err_q;

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] data_k;
    logic            busy_k;
    assign ra = rd_addr[k*AW +: AW];

    always_comb begin
      data_k = rf_q[ra];
      busy_k = busy_q[ra];
      if (ra == '0) begin
        data_k = '0;
        busy_k = 1'b0;
      end else if (BYPASS != 0) begin
        if (wr1_ok && (wr1_addr == ra)) data_k = wr1_data;
        else if (wr0_ok && (wr0_addr == ra)) data_k = wr0_val;
        // A load landing this cycle releases the register unless it is re-claimed
        if (wr1_ok && (wr1_addr == ra) && !(sb_ok && (sb_addr == ra))) busy_k = 1'b0;
      end
    end

    assign rd_data[k*XLEN +: XLEN] = data_k;
    assign rd_busy[k]              = busy_k;
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_regfile_mp : self-checking bench for regfile_mp (default parameters).
//                 Revision 1.0
// ----------------------------------------------------------------------------
module tb_regfile_mp;
  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int AW    = 5;

  logic                clk = 1'b0;
  logic                reset;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic                wr0_en;
  logic [AW-1:0]       wr0_addr;
  logic [1:0]          wr0_src;
  logic [XLEN-1:0]     wr0_data, wr0_pc4, wr0_npc;
  logic                wr1_en;
  logic [AW-1:0]       wr1_addr;
  logic [XLEN-1:0]     wr1_data;
  logic                sb_set;
  logic [AW-1:0]       sb_addr;
  logic                clear_req;
  logic                clear_busy;
  logic                wr_err;

  int checks = 0;
  int errors = 0;
  logic [XLEN-1:0] model [NREGS];
  logic            mbusy [NREGS];
  logic [XLEN-1:0] exp_q [$];
  logic [XLEN-1:0] e0, e1;

  always #5 clk = ~clk;

  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .BYPASS(1)) dut (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_src(wr0_src), .wr0_data(wr0_data),
    .wr0_pc4(wr0_pc4), .wr0_npc(wr0_npc), .wr1_en(wr1_en), .wr1_addr(wr1_addr),
    .wr1_data(wr1_data), .sb_set(sb_set), .sb_addr(sb_addr), .clear_req(clear_req),
    .clear_busy(clear_busy), .wr_err(wr_err)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic quiet;
    wr0_en = 1'b0; wr1_en = 1'b0; sb_set = 1'b0; clear_req = 1'b0;
  endtask

  task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    rd_addr = {a1, a0};
  endtask

  task automatic test_reset;
    quiet();
    wr0_addr = '0; wr0_src = 2'b00; wr0_data = '0; wr0_pc4 = '0; wr0_npc = '0;
    wr1_addr = '0; wr1_data = '0; sb_addr = '0;
    set_rd(5'd1, 5'd31);
    reset = 1'b1;
    for (int i = 0; i < NREGS; i++) begin model[i] = '0; mbusy[i] = 1'b0; end
    repeat (2) tick();
    checks++;
    if (clear_busy !== 1'b0) begin errors++; $display("FAIL reset_clear_busy got %b exp 0", clear_busy); end
    checks++;
    if (wr_err !== 1'b0) begin errors++; $display("FAIL reset_wr_err got %b exp 0", wr_err); end
    reset = 1'b0;
    exp_q.push_back(model[1]); exp_q.push_back(model[31]);
    #1;
    e0 = exp_q.pop_front(); e1 = exp_q.pop_front();
    checks++;
    if (rd_data[31:0] !== e0) begin errors++; $display("FAIL reset_rd0 got %h exp %h", rd_data[31:0], e0); end
    checks++;
    if (rd_data[63:32] !== e1) begin errors++; $display("FAIL reset_rd1 got %h exp %h", rd_data[63:32], e1); end
    checks++;
    if (rd_busy !== 2'b00) begin errors++; $display("FAIL reset_busy got %b exp 00", rd_busy); end
  endtask

  task automatic test_write_read;
    wr0_en = 1'b1; wr0_addr = 5'd5; wr0_src = 2'b00; wr0_data = 32'hDEADBEEF;
    model[5] = 32'hDEADBEEF;
    tick(); quiet();
    set_rd(5'd5, 5'd0);
    exp_q.push_back(model[5]);
    #1;
    e0 = exp_q.pop_front();
    checks++;
    if (rd_data[31:0] !== e0) begin errors++; $display("FAIL wr0_read5 got %h exp %h", rd_data[31:0], e0); end
    // write to r0 is discarded, also not forwarded
    wr0_en = 1'b1; wr0_addr = 5'd0; wr0_src = 2'b00; wr0_data = 32'h1;
    set_rd(5'd0, 5'd0);
    exp_q.push_back(32'h0);
    #1;
    e0 = exp_q.pop_front();
    checks++;
    if (rd_data[31:0] !== e0) begin errors++; $display("FAIL r0_bypass got %h exp %h", rd_data[31:0], e0); end
    tick(); quiet();
    exp_q.push_back(32'h0);
    #1;
    e0 = exp_q.pop_front();
    checks++;
    if (rd_data[31:0] !== e0) begin errors++; $display("FAIL r0_read got %h exp %h", rd_data[31:0], e0); end
    wr0_en = 1'b1; wr0_addr = 5'd10; wr0_src = 2'b01;
    wr0_data = 32'h111; wr0_pc4 = 32'h104; wr0_npc = 32'h222;
    model[10] = 32'h104;
    tick();
    wr0_addr = 5'd11; wr0_src = 2'b10;
    wr0_data = 32'h333; wr0_pc4 = 32'h444; wr0_npc = 32'h555;
    model[11] = 32'h555;
    set_rd(5'd10, 5'd11);
    exp_q.push_back(model[10]); exp_q.push_back(model[11]);
    #1;
    e0 = exp_q.pop_front(); e1 = exp_q.pop_front();
    checks++;
    if (rd_data[31:0] !== e0) begin errors++; $display("FAIL src_pc4 got %h exp %h", rd_data[31:0], e0); end
    checks++;
    if (rd_data[63:32] !== e1) begin errors++; $display("FAIL src_npc_bypass got %h exp %h", rd_data[63:32], e1); end
    tick(); quiet();
    checks++;
    if (wr_err !== 1'b0) begin errors++; $display("FAIL legal_no_err got %b exp 0", wr_err); end
  endtask

  task automatic test_bypass;
    wr1_en = 1'b1; wr1_addr = 5'd7; wr1_data = 32'h12345678;
    set_rd(5'd0, 5'd7);
    exp_q.push_back(32'h12345678);
    model[7] = 32'h12345678;
    #1;
    e1 = exp_q.pop_front();
    checks++;
    if (rd_data[63:32] !== e1) begin errors++; $display("FAIL bypass_wr1 got %h exp %h", rd_data[63:32], e1); end
    tick(); quiet();
    // both ports target r12: P1 value must be forwarded and stored
    wr0_en = 1'b1; wr0_addr = 5'd12; wr0_src = 2'b00; wr0_data = 32'hBBBB;
    wr1_en = 1'b1; wr1_addr = 5'd12; wr1_data = 32'hCCCC;
    model[12] = 32'hCCCC;
    set_rd(5'd12, 5'd7);
    exp_q.push_back(model[12]);
    #1;
    e0 = exp_q.pop_front();
    checks++;
    if (rd_data[31:0] !== e0) begin errors++; $display("FAIL bypass_prio got %h exp %h", rd_data[31:0], e0); end
    tick(); quiet();
    checks++;
    if (wr_err !== 1'b1) begin errors++; $display("FAIL bypass_collide_err got %b exp 1", wr_err); end
    exp_q.push_back(model[12]);
    #1;
    e0 = exp_q.pop_front();
    checks++;
    if (rd_data[31:0] !== e0) begin errors++; $display("FAIL collide_store12 got %h exp %h", rd_data[31:0], e0); end
  endtask

  task automatic test_collision;
    wr0_en = 1'b1; wr0_addr = 5'd9; wr0_src = 2'b01; wr0_pc4 = 32'h104;
    wr1_en = 1'b1; wr1_addr = 5'd9; wr1_data = 32'hAA;
    model[9] = 32'hAA;
    tick(); quiet();
    checks++;
    if (wr_err !== 1'b1) begin errors++; $display("FAIL t3_err_set got %b exp 1", wr_err); end
    set_rd(5'd9, 5'd0);
    exp_q.push_back(model[9]);
    #1;
    e0 = exp_q.pop_front();
    checks++;
    if (rd_data[31:0] !== e0) begin errors++; $display("FAIL t3_rf9 got %h exp %h", rd_data[31:0], e0); end
    tick();
    checks++;
    if (wr_err !== 1'b0) begin errors++; $display("FAIL t3_err_clear got %b exp 0", wr_err); end
    wr0_en = 1'b1; wr0_addr = 5'd13; wr0_src = 2'b11; wr0_data = 32'hDEAD;
    set_rd(5'd13, 5'd0);
    exp_q.push_back(model[13]);
    #1;
    e0 = exp_q.pop_front();
    checks++;
    if (rd_data[31:0] !== e0) begin errors++; $display("FAIL ill_no_bypass got %h exp %h", rd_data[31:0], e0); end
    tick(); quiet();
    checks++;
    if (wr_err !== 1'b1) begin errors++; $display("FAIL ill_err got %b exp 1", wr_err); end
    exp_q.push_back(model[13]);
    #1;
    e0 = exp_q.pop_front();
    checks++;
    if (rd_data[31:0] !== e0) begin errors++; $display("FAIL ill_no_write got %h exp %h", rd_data[31:0], e0); end
    tick();
    checks++;
    if (wr_err !== 1'b0) begin errors++; $display("FAIL ill_err_clear got %b exp 0", wr_err); end
  endtask

  task automatic test_scoreboard;
    sb_set = 1'b1; sb_addr = 5'd3;
    set_rd(5'd3, 5'd0);
    #1;
    checks++;
    if (rd_busy[0] !== 1'b0) begin errors++; $display("FAIL sb_not_yet got %b exp 0", rd_busy[0]); end
    mbusy[3] = 1'b1;
    tick(); quiet();
    checks++;
    if (rd_busy[0] !== mbusy[3]) begin errors++; $display("FAIL sb_set3 got %b exp %b", rd_busy[0], mbusy[3]); end
    sb_set = 1'b1; sb_addr = 5'd3; wr1_en = 1'b1; wr1_addr = 5'd3; wr1_data = 32'h33;
    model[3] = 32'h33;
    #1;
    checks++;
    if (rd_busy[0] !== 1'b1) begin errors++; $display("FAIL sb_setclr_same got %b exp 1", rd_busy[0]); end
    tick(); quiet();
    checks++;
    if (rd_busy[0] !== mbusy[3]) begin errors++; $display("FAIL sb_set_wins got %b exp %b", rd_busy[0], mbusy[3]); end
    wr1_en = 1'b1; wr1_addr = 5'd3; wr1_data = 32'h44;
    model[3] = 32'h44; mbusy[3] = 1'b0;
    #1;
    checks++;
    if (rd_busy[0] !== 1'b0) begin errors++; $display("FAIL sb_clr_bypass got %b exp 0", rd_busy[0]); end
    tick(); quiet();
    checks++;
    if (rd_busy[0] !== mbusy[3]) begin errors++; $display("FAIL sb_clr got %b exp %b", rd_busy[0], mbusy[3]); end
    sb_set = 1'b1; sb_addr = 5'd0;
    tick(); quiet();
    set_rd(5'd3, 5'd0);
    #1;
    checks++;
    if (rd_busy[1] !== 1'b0) begin errors++; $display("FAIL sb_r0 got %b exp 0", rd_busy[1]); end
  endtask

  task automatic test_sweep;
    int n;
    for (int a = 1; a < NREGS; a++) begin
      wr0_en = 1'b1; wr0_addr = AW'(a); wr0_src = 2'b00; wr0_data = $urandom | 32'h1;
      model[a] = wr0_data;
      tick();
    end
    quiet();
    sb_set = 1'b1; sb_addr = 5'd20; mbusy[20] = 1'b1;
    tick(); quiet();
    set_rd(5'd20, 5'd0);
    #1;
    checks++;
    if (rd_busy[0] !== mbusy[20]) begin errors++; $display("FAIL sweep_pre_busy got %b exp %b", rd_busy[0], mbusy[20]); end
    clear_req = 1'b1;
    tick(); clear_req = 1'b0;
    // writes held during the sweep must be ignored and never forwarded
    wr0_en = 1'b1; wr0_addr = 5'd31; wr0_src = 2'b00; wr0_data = 32'hFFFF_FFFF;
    set_rd(5'd2, 5'd31);
    n = 0;
    while (clear_busy === 1'b1 && n < 100) begin
      n++;
      if (n == 5) begin
        exp_q.push_back(32'h0); exp_q.push_back(model[31]);
        e0 = exp_q.pop_front(); e1 = exp_q.pop_front();
        checks++;
        if (rd_data[31:0] !== e0) begin errors++; $display("FAIL sweep_partial2 got %h exp %h", rd_data[31:0], e0); end
        checks++;
        if (rd_data[63:32] !== e1) begin errors++; $display("FAIL sweep_partial31 got %h exp %h", rd_data[63:32], e1); end
      end
      tick();
    end
    quiet();
    checks++;
    if (n != 31) begin errors++; $display("FAIL sweep_len got %0d exp 31", n); end
    for (int i = 0; i < NREGS; i++) begin model[i] = '0; mbusy[i] = 1'b0; end
    for (int a = 0; a < NREGS; a++) begin
      set_rd(AW'(a), 5'd0);
      exp_q.push_back(model[a]);
      #1;
      e0 = exp_q.pop_front();
      checks++;
      if (rd_data[31:0] !== e0 || rd_busy[0] !== mbusy[a])
        begin errors++; $display("FAIL sweep_clear r%0d got %h/%b exp %h/%b", a, rd_data[31:0], rd_busy[0], e0, mbusy[a]); end
    end
  endtask

  task automatic test_reset_mid_sweep;
    int n;
    wr0_en = 1'b1; wr0_addr = 5'd30; wr0_src = 2'b00; wr0_data = 32'h3030; tick();
    wr0_addr = 5'd31; wr0_data = 32'h3131; tick();
    quiet();
    clear_req = 1'b1;
    tick(); clear_req = 1'b0;
    n = 0;
    while (clear_busy === 1'b1 && n < 10) begin n++; tick(); end
    checks++;
    if (n != 10) begin errors++; $display("FAIL midrst_progress got %0d exp 10", n); end
    #2;
    reset = 1'b1;
    set_rd(5'd31, 5'd30);
    exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    #1;
    e0 = exp_q.pop_front(); e1 = exp_q.pop_front();
    checks++;
    if (clear_busy !== 1'b0) begin errors++; $display("FAIL midrst_clear_busy got %b exp 0", clear_busy); end
    checks++;
    if (rd_data[31:0] !== e0 || rd_data[63:32] !== e1)
      begin errors++; $display("FAIL midrst_regs got %h %h exp %h %h", rd_data[31:0], rd_data[63:32], e0, e1); end
    tick();
    reset = 1'b0;
    clear_req = 1'b1;
    tick(); clear_req = 1'b0;
    checks++;
    if (clear_busy !== 1'b1) begin errors++; $display("FAIL midrst_restart got %b exp 1", clear_busy); end
    n = 0;
    while (clear_busy === 1'b1 && n < 100) begin n++; tick(); end
    checks++;
    if (n != 31) begin errors++; $display("FAIL midrst_sweep_len got %0d exp 31", n); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_collision();
    test_scoreboard();
    test_sweep();
    test_reset_mid_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
